// File: rtl/audio_pwm_pkg.sv
// audio_pwm_pkg
//   Shared constants and types for the audio PWM slice.
//   DATA_W_DEF / CHANNELS_DEF / FIFO_DEPTH_DEF : default block geometry
//   frame_t                                    : one multi-channel sample frame
//                                                (channel c at [c*DATA_W +: DATA_W])
//   level_w()                                  : width of a FIFO occupancy count
package audio_pwm_pkg;

   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned CHANNELS_DEF   = 2;
   localparam int unsigned FIFO_DEPTH_DEF = 16;
   localparam int unsigned FRAME_W_DEF    = DATA_W_DEF * CHANNELS_DEF;

   typedef logic [FRAME_W_DEF-1:0] frame_t;

   // Occupancy needs one bit more than the address so that "full" is representable.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/audio_pwm_fifo.sv
// audio_fifo
//   Single-clock, show-ahead sample-frame FIFO. pop_data always presents the
//   head entry; full/empty/level are registered.
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     push, push_data : write request and frame (ignored while full)
//     pop             : consume head (ignored while empty)
//     pop_data        : head frame (valid when empty is low)
//     full, empty     : registered status
//     level           : number of frames stored
module audio_fifo
   import audio_pwm_pkg::*;
#(
   parameter int unsigned WIDTH = FRAME_W_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [level_w(DEPTH)-1:0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_ONE     = (AW+1)'(1);
   localparam logic [AW:0] LVL_FULL_M1 = (AW+1)'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Acceptance depends only on registered status, so a full FIFO refuses
   // a push even when a pop frees a slot in the same cycle.
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10: begin
               level <= level + 1'b1;
               full  <= (level == LVL_FULL_M1);
               empty <= 1'b0;
            end
            2'b01: begin
               level <= level - 1'b1;
               empty <= (level == LVL_ONE);
               full  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/audio_pwm.sv
// audio_pwm
//   Multi-channel PWM audio output fed from a frame FIFO. A free-running
//   DATA_W-bit counter defines a 2^DATA_W-cycle period; at the last count the
//   FIFO head is loaded into the duty registers (or underrun pulses and the
//   old duty is held). pwm_out[c] is registered (cnt < duty[c]).
//   Optional build macro AUDIO_PWM_VOLUME_EN adds a 3-bit volume input that
//   right-shifts each sample at load.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     sample_valid  : frame offered this cycle
//     sample_data   : frame, channel c at [c*DATA_W +: DATA_W]
//     sample_ready  : FIFO not full
//     pwm_out       : one PWM bit per channel
//     fifo_level    : frames buffered
//     underrun      : one-cycle pulse when a load finds the FIFO empty
//     volume        : (AUDIO_PWM_VOLUME_EN only) attenuation shift
module audio_pwm
   import audio_pwm_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned CHANNELS   = CHANNELS_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]     sample_data,
   output logic                           sample_ready,
   output logic [CHANNELS-1:0]            pwm_out,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           underrun
`ifdef AUDIO_PWM_VOLUME_EN
   ,
   input  logic [2:0]                     volume
`endif
);

   logic [DATA_W-1:0]          cnt;
   logic [DATA_W-1:0]          duty      [CHANNELS];
   logic [DATA_W-1:0]          next_duty [CHANNELS];
   logic [CHANNELS*DATA_W-1:0] head;
   logic                       full;
   logic                       empty;
   logic                       load;
   logic                       pop;

   assign load         = (cnt == '1);
   assign pop          = load & ~empty;
   assign sample_ready = ~full;

   audio_fifo #(
      .WIDTH (CHANNELS * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (sample_valid),
      .push_data (sample_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   always_comb begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
`ifdef AUDIO_PWM_VOLUME_EN
         next_duty[c] = head[c*DATA_W +: DATA_W] >> volume;
`else
         next_duty[c] = head[c*DATA_W +: DATA_W];
`endif
      end
   end

   // Duty is written on the edge that wraps cnt to 0, so the new value governs
   // the whole following period; pwm_out lags cnt by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         underrun <= 1'b0;
         pwm_out  <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) duty[c] <= '0;
      end else begin
         cnt      <= cnt + 1'b1;
         underrun <= load & empty;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (pop) duty[c] <= next_duty[c];
            pwm_out[c] <= (cnt < duty[c]);
         end
      end
   end

endmodule

// File: tb/tb_audio_pwm.sv
// tb_audio_pwm
//   Directed bench for audio_pwm (default geometry: 8-bit, 2 channels, depth 16).
//   cnt_ref tracks the period counter phase from reset release; inputs are
//   driven and outputs sampled on the falling edge.
module tb_audio_pwm;
   import audio_pwm_pkg::*;

   localparam int unsigned CH = 2;
   localparam int unsigned LW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          sample_valid;
   frame_t        sample_data;
   logic          sample_ready;
   logic [CH-1:0] pwm_out;
   logic [LW-1:0] fifo_level;
   logic          underrun;
`ifdef AUDIO_PWM_VOLUME_EN
   logic [2:0]    volume;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int unsigned cnt_ref = 0;
   int h0, h1;

   always #5 clk = ~clk;

   audio_pwm #(
      .DATA_W     (8),
      .CHANNELS   (2),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .fifo_level   (fifo_level),
      .underrun     (underrun)
`ifdef AUDIO_PWM_VOLUME_EN
      ,
      .volume       (volume)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      cnt_ref = (cnt_ref + 1) % 256;
   endtask

   task automatic run_to(input int unsigned target);
      while (cnt_ref != target) cycle();
   endtask

   task automatic push_frame(input logic [7:0] c1, input logic [7:0] c0);
      sample_valid = 1'b1;
      sample_data  = {c1, c0};
      cycle();
      sample_valid = 1'b0;
   endtask

   task automatic measure(output int a0, output int a1);
      a0 = 0;
      a1 = 0;
      repeat (256) begin
         cycle();
         a0 += int'(pwm_out[0]);
         a1 += int'(pwm_out[1]);
      end
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
`ifdef AUDIO_PWM_VOLUME_EN
      volume       = 3'd0;
`endif
      repeat (3) @(negedge clk);
      check("rst_pwm",      32'(pwm_out),      0);
      check("rst_level",    32'(fifo_level),   0);
      check("rst_ready",    32'(sample_ready), 1);
      check("rst_underrun", 32'(underrun),     0);

      reset   = 1'b0;
      cnt_ref = 0;

      // Duty accuracy: ch1=64, ch0=128
      push_frame(8'd64, 8'd128);
      check("push_level", 32'(fifo_level), 1);
      run_to(255);
      check("preload_level", 32'(fifo_level), 1);
      cycle();
      check("load_level",    32'(fifo_level), 0);
      check("load_underrun", 32'(underrun),   0);
      measure(h0, h1);
      check("duty_ch0", 32'(h0), 128);
      check("duty_ch1", 32'(h1), 64);

      // Underrun: FIFO empty at that wrap
      check("underrun_pulse", 32'(underrun), 1);
      cycle();
      check("underrun_1cyc", 32'(underrun), 0);
      measure(h0, h1);
      check("held_ch0", 32'(h0), 128);
      check("held_ch1", 32'(h1), 64);

      // Extremes: ch0=255, ch1=0
      push_frame(8'd0, 8'd255);
      run_to(0);
      check("ext_underrun", 32'(underrun), 0);
      measure(h0, h1);
      check("ext_ch0", 32'(h0), 255);
      check("ext_ch1", 32'(h1), 0);

      // Full boundary: 17 back-to-back pushes, frame i = {200-8i, 8(i+1)}
      for (int i = 0; i < 17; i++) push_frame(8'(200 - 8*i), 8'(8*(i+1)));
      check("full_level", 32'(fifo_level),   16);
      check("full_ready", 32'(sample_ready), 0);
      run_to(0);
      check("load1_level",    32'(fifo_level),   15);
      check("load1_ready",    32'(sample_ready), 1);
      check("load1_underrun", 32'(underrun),     0);
      // Push coinciding with pop: level unchanged, new frame queued last
      run_to(255);
      push_frame(8'd33, 8'd77);
      check("simul_level",    32'(fifo_level), 15);
      check("load2_underrun", 32'(underrun),   0);
      measure(h0, h1);
      check("order_ch0", 32'(h0), 16);
      check("order_ch1", 32'(h1), 192);
      check("load3_underrun", 32'(underrun), 0);
      for (int k = 4; k <= 17; k++) begin
         repeat (256) cycle();
         check("drain_underrun", 32'(underrun), 0);
      end
      check("drained_level", 32'(fifo_level), 0);
      repeat (256) cycle();
      check("drop_underrun", 32'(underrun), 1);
      measure(h0, h1);
      check("last_ch0", 32'(h0), 77);
      check("last_ch1", 32'(h1), 33);

`ifdef AUDIO_PWM_VOLUME_EN
      // Volume: 200 >> 2 = 50
      volume = 3'd2;
      push_frame(8'd200, 8'd200);
      run_to(0);
      measure(h0, h1);
      check("vol_ch0", 32'(h0), 50);
      check("vol_ch1", 32'(h1), 50);
      volume = 3'd0;
      run_to(0);
`endif

      // Reset mid-period with frames buffered and outputs high
      push_frame(8'd200, 8'd150);
      run_to(0);
      push_frame(8'd20, 8'd10);
      push_frame(8'd40, 8'd30);
      run_to(100);
      check("prerst_pwm",   32'(pwm_out),    3);
      check("prerst_level", 32'(fifo_level), 2);
      #1 reset = 1'b1;
      #1;
      check("midrst_pwm",      32'(pwm_out),      0);
      check("midrst_level",    32'(fifo_level),   0);
      check("midrst_ready",    32'(sample_ready), 1);
      check("midrst_underrun", 32'(underrun),     0);
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      cnt_ref = 0;
      push_frame(8'd64, 8'd128);
      run_to(255);
      check("restart_pwm",   32'(pwm_out),    0);
      check("restart_level", 32'(fifo_level), 1);
      cycle();
      check("restart_load",     32'(fifo_level), 0);
      check("restart_underrun", 32'(underrun),   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/audio_pwm.md
AUDIO_PWM -- requirements
Module: audio_pwm

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width in bits; also sets the PWM period of 2^DATA_W clk cycles.
REQ-002 SHALL have parameter CHANNELS, default 2: number of independent PWM outputs.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: sample-frame buffer depth, a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sample_valid, input, 1: frame offered this cycle.
REQ-007 SHALL have port sample_data, input, CHANNELS*DATA_W: frame; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-008 SHALL have port sample_ready, output, 1: high when the FIFO is not full.
REQ-009 SHALL have port pwm_out, output, CHANNELS: registered PWM output, one bit per channel.
REQ-010 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: number of frames currently buffered.
REQ-011 SHALL have port underrun, output, 1: one-cycle pulse when a frame load finds the FIFO empty.

Function
REQ-012 SHALL accept a frame into the FIFO on every clk edge where sample_valid and sample_ready are both high.
REQ-013 SHALL derive sample_ready from registered FIFO state only; when full, a push is refused even if a pop occurs in the same cycle.
REQ-014 SHALL run a free-running DATA_W-bit period counter cnt that increments each cycle and wraps from 2^DATA_W-1 to 0.
REQ-015 SHALL, in the cycle where cnt == 2^DATA_W-1, pop the FIFO head into the per-channel duty registers if the FIFO is not empty.
REQ-016 SHALL make new duty values take effect from the cycle where cnt == 0.
REQ-017 SHALL, if the FIFO is empty at that load cycle, hold the previous duty values and pulse underrun for exactly one cycle.
REQ-018 SHALL register pwm_out[c] as (cnt < duty[c]), giving one cycle of output latency.
REQ-019 SHALL produce, for duty 0, a constantly low output, and for duty 2^DATA_W-1, an output high for 2^DATA_W-1 of every 2^DATA_W cycles.
REQ-020 SHALL, on a simultaneous push and pop, leave fifo_level unchanged and preserve frame order.
REQ-021 SHALL treat a push into an empty FIFO in the load cycle as an underrun; the pushed frame is loaded at the next wrap.

Reset
REQ-022 SHALL, while reset is high, immediately force: cnt=0, all duty=0, pwm_out=0, underrun=0, FIFO empty, fifo_level=0, sample_ready=1.
REQ-023 SHALL, on reset assertion mid-period, discard all buffered frames and restart the period from cnt=0 after reset is released.

Configuration
REQ-024 SHALL, when AUDIO_PWM_VOLUME_EN is defined, add input port volume, 3 bits, and load duty[c] = sample >> volume at each frame load.
REQ-025 SHALL, when AUDIO_PWM_VOLUME_EN is undefined, have no volume port and load duty[c] = sample unmodified.

Structure
REQ-026 SHALL place the default DATA_W, CHANNELS and FIFO_DEPTH constants and the frame typedef in shared package audio_pwm_pkg.
REQ-027 SHALL implement the buffer as sub-module audio_fifo: synchronous, single-clock, show-ahead, providing full/empty/level.

Verification
REQ-028 SHALL cover reset: assert reset at cnt=100 -> pwm_out=0, fifo_level=0 and sample_ready=1 immediately; the period restarts at 0 after release.
REQ-029 SHALL cover duty accuracy: push {ch1=64, ch0=128} -> after the next wrap, ch0 is high 128 and ch1 high 64 cycles per 256-cycle period.
REQ-030 SHALL cover extremes: push {255, 0} -> ch0 high 255 of 256 cycles; ch1 never high.
REQ-031 SHALL cover the full boundary: push 17 frames with no pop -> fifo_level=16, sample_ready=0, and the 17th frame dropped.
REQ-032 SHALL cover underrun: empty FIFO at wrap -> underrun high for 1 cycle and previous duty held for the next period.
REQ-033 SHALL cover volume, with AUDIO_PWM_VOLUME_EN defined: volume=2 and sample 200 -> output high 50 of 256 cycles.
